ram_byte_dma: RTL and testbench

Avalon-MM initiator that moves byte streams into and out of the 32-bit single-port on-chip RAM (10240 words, fixed read latency). A command port selects the direction, start byte address and length. In write mode the block packs an incoming byte stream into byte-enabled word writes. In read mode it issues word reads and unpacks them into an outgoing byte stream. It sits between the I2C byte datapath and the RAM's Avalon slave.

---
 rtl/ram_dma_pkg.sv | 23 ++
 rtl/ram_dma_lane_buf.sv | 61 ++++++
 rtl/ram_byte_dma.sv | 174 +++++++++++++++++
 tb/tb_ram_byte_dma.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the byte-stream <-> word RAM DMA block.
package ram_dma_pkg;

    localparam int LANES      = 4;
    localparam int LANE_W     = 8;
    localparam logic [1:0] LAST_LANE = 2'd3;
    localparam logic [3:0] BE_ALL    = 4'hF;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DEPTH  = 10240;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WFILL  = 3'd1,
        ST_WWRITE = 3'd2,
        ST_RREQ   = 3'd3,
        ST_RWAIT  = 3'd4,
        ST_RDRAIN = 3'd5,
        ST_FIN    = 3'd6
    } dma_state_e;

endpackage

// File: rtl/ram_dma_lane_buf.sv
// Word staging buffer: packs bytes into a 32-bit word (write) or unpacks a
// loaded word byte by byte (read). Tracks the current lane and lane mask.
module ram_dma_lane_buf
    import ram_dma_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,      // new command: clear, lane = start lane
    input  logic [1:0]  i_start_lane,
    input  logic        i_clr,        // word flushed: clear, lane = 0
    input  logic        i_ins,        // insert byte at current lane
    input  logic [7:0]  i_byte,
    input  logic        i_load,       // load a whole word from the RAM
    input  logic [31:0] i_word,
    input  logic        i_adv,        // current byte consumed
    input  logic        i_rem_one,    // the byte at the current lane is the last one
    output logic [31:0] o_word,
    output logic [3:0]  o_mask,
    output logic [1:0]  o_lane,
    output logic [7:0]  o_byte,
    output logic        o_full,
    output logic        o_last
);

    logic [31:0] r_word;
    logic [3:0]  r_mask;
    logic [1:0]  r_lane;

    // Word/mask/lane update; start and clear zero the word so unfilled lanes read as 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
            r_mask <= '0;
            r_lane <= '0;
        end else if (i_start) begin
            r_word <= '0;
            r_mask <= '0;
            r_lane <= i_start_lane;
        end else if (i_clr) begin
            r_word <= '0;
            r_mask <= '0;
            r_lane <= '0;
        end else if (i_ins) begin
            r_word[{r_lane, 3'b000} +: LANE_W] <= i_byte;
            r_mask[r_lane]                     <= 1'b1;
            r_lane                             <= r_lane + 2'd1;
        end else if (i_load) begin
            r_word <= i_word;
        end else if (i_adv) begin
            r_lane <= r_lane + 2'd1;
        end
    end

    assign o_word = r_word;
    assign o_mask = r_mask;
    assign o_lane = r_lane;
    assign o_byte = r_word[{r_lane, 3'b000} +: LANE_W];
    assign o_full = (r_lane == LAST_LANE);
    assign o_last = o_full | i_rem_one;

endmodule

// File: rtl/ram_byte_dma.sv
// Avalon-MM initiator moving byte streams into / out of a 32-bit word RAM.
// Write mode packs bytes into byte-enabled word writes; read mode issues
// word reads and unpacks them into a byte stream.
module ram_byte_dma
    import ram_dma_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int READ_LATENCY = 1,
    parameter int LEN_W        = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W+1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Range check is done one bit wider than either operand so it cannot alias.
    localparam int SUM_W = (((ADDR_W + 2) > LEN_W) ? (ADDR_W + 2) : LEN_W) + 1;
    localparam logic [SUM_W-1:0] BYTE_LIMIT = SUM_W'(DEPTH * LANES);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    dma_state_e          r_state;
    logic [ADDR_W-1:0]   r_waddr;
    logic [LEN_W-1:0]    r_rem;
    logic                r_err;
    logic [LAT_W-1:0]    r_lat;

    logic [SUM_W-1:0]    w_end;
    logic                w_reject;
    logic                w_accept;
    logic                w_s_hs;
    logic                w_m_hs;
    logic                w_rd_cap;
    logic                w_rem_one;
    logic [31:0]         w_word;
    logic [3:0]          w_mask;
    logic [1:0]          w_lane;
    logic [7:0]          w_byte;
    logic                w_full;
    logic                w_last;

    assign w_end     = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign w_reject  = (cmd_len == '0) || (w_end > BYTE_LIMIT);
    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    assign w_s_hs    = (r_state == ST_WFILL) && s_valid;
    assign w_m_hs    = (r_state == ST_RDRAIN) && m_ready;
    assign w_rd_cap  = (r_state == ST_RWAIT) && (r_lat == LAT_LAST);
    assign w_rem_one = (r_rem == LEN_W'(1));

    ram_dma_lane_buf u_lane_buf (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_start      (w_accept && !w_reject),
        .i_start_lane (cmd_addr[1:0]),
        .i_clr        (r_state == ST_WWRITE),
        .i_ins        (w_s_hs),
        .i_byte       (s_data),
        .i_load       (w_rd_cap),
        .i_word       (avm_readdata),
        .i_adv        (w_m_hs),
        .i_rem_one    (w_rem_one),
        .o_word       (w_word),
        .o_mask       (w_mask),
        .o_lane       (w_lane),
        .o_byte       (w_byte),
        .o_full       (w_full),
        .o_last       (w_last)
    );

    // FSM plus word-address, remaining-length and read-latency counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_waddr <= '0;
            r_rem   <= '0;
            r_err   <= 1'b0;
            r_lat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_err <= w_reject;
                        if (w_reject) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_waddr <= cmd_addr[ADDR_W+1:2];
                            r_rem   <= cmd_len;
                            r_state <= cmd_write ? ST_WFILL : ST_RREQ;
                        end
                    end
                end
                ST_WFILL: begin
                    if (s_valid) begin
                        r_rem <= r_rem - LEN_W'(1);
                        if (w_last) r_state <= ST_WWRITE;
                    end
                end
                ST_WWRITE: begin
                    r_waddr <= r_waddr + ADDR_W'(1);
                    r_state <= (r_rem == '0) ? ST_FIN : ST_WFILL;
                end
                ST_RREQ: begin
                    r_lat   <= '0;
                    r_state <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    if (r_lat == LAT_LAST) r_state <= ST_RDRAIN;
                    else                   r_lat   <= r_lat + LAT_W'(1);
                end
                ST_RDRAIN: begin
                    if (m_ready) begin
                        r_rem <= r_rem - LEN_W'(1);
                        if (w_last) begin
                            if (w_rem_one) begin
                                r_state <= ST_FIN;
                            end else begin
                                r_waddr <= r_waddr + ADDR_W'(1);
                                r_state <= ST_RREQ;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so everything idles at 0 out of reset
    always_comb begin
        cmd_ready      = (r_state == ST_IDLE);
        busy           = (r_state != ST_IDLE);
        done           = (r_state == ST_FIN);
        err            = (r_state == ST_FIN) && r_err;
        s_ready        = (r_state == ST_WFILL);
        m_valid        = (r_state == ST_RDRAIN);
        m_data         = m_valid ? w_byte : 8'h00;
        avm_chipselect = (r_state == ST_WWRITE) || (r_state == ST_RREQ);
        avm_write      = (r_state == ST_WWRITE);
        avm_address    = avm_chipselect ? r_waddr : '0;
        avm_writedata  = avm_write ? w_word : 32'h0;
        avm_byteenable = 4'h0;
        if (r_state == ST_WWRITE)    avm_byteenable = w_mask;
        else if (r_state == ST_RREQ) avm_byteenable = BE_ALL;
    end

    // Lane index and full flag only feed the buffer's own last-beat logic here
    logic w_unused;
    assign w_unused = ^{w_lane, w_full};

endmodule

// File: tb/tb_ram_byte_dma.sv
// Scoreboard bench for ram_byte_dma: stimulus pushes expected bus writes,
// stream bytes and done/err results; a monitor pops and compares.
module tb_ram_byte_dma;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 10240;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W+1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [7:0]        s_data;
    logic              s_valid, s_ready;
    logic [7:0]        m_data;
    logic              m_valid, m_ready;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect, avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              busy, done, err;

    always #5 clk = ~clk;

    ram_byte_dma #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(1), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .err(err)
    );

    // RAM model, one-cycle read latency
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin : ram_model
        logic [31:0] tmp;
        if (avm_chipselect && avm_write) begin
            tmp = mem[avm_address];
            for (int b = 0; b < 4; b++)
                if (avm_byteenable[b]) tmp[8*b +: 8] = avm_writedata[8*b +: 8];
            mem[avm_address] <= tmp;
        end
        if (avm_chipselect && !avm_write) avm_readdata <= mem[avm_address];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [3:0]        be;
        logic [31:0]       d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic       exp_done[$];

    int n_chk = 0;
    int n_fail = 0;
    int n_reads = 0;
    int n_hs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    // Monitor: samples on the falling edge, compares against the queues
    initial begin : monitor
        logic       prev_stall;
        logic [7:0] prev_data;
        wr_t        ew;
        logic [7:0] eb;
        logic       ee;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_stall) chk("bp_hold", {m_valid, m_data}, {1'b1, prev_data});
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (avm_chipselect && avm_write) begin
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_addr", avm_address, ew.a);
                    chk("wr_be", avm_byteenable, ew.be);
                    chk("wr_data", avm_writedata, ew.d);
                end
            end
            if (avm_chipselect && !avm_write) begin
                n_reads++;
                chk("rd_be", avm_byteenable, 4'hF);
            end
            if (m_valid && m_ready) begin
                n_hs++;
                if (exp_rd.size() == 0) fail_now("unexpected_byte");
                else begin
                    eb = exp_rd.pop_front();
                    chk("m_data", m_data, eb);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else begin
                    ee = exp_done.pop_front();
                    chk("done_err", err, ee);
                end
            end
        end
    end

    task automatic issue_cmd(input logic w, input logic [15:0] a, input logic [15:0] l);
        int k;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        if (!cmd_ready) $display("FAIL cmd_timeout: cmd_ready %0b, expected 1", cmd_ready);
        if (!cmd_ready) begin n_chk++; n_fail++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        s_valid = 1'b1; s_data = b;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 50) begin @(negedge clk); k++; end
        if (!s_ready) begin
            n_chk++; n_fail++;
            $display("FAIL s_ready_timeout: s_ready %0b, expected 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_done.size() != 0 && k < 500) begin @(posedge clk); k++; end
        #1;
        chk("done_seen", exp_done.size(), 0);
        chk("wr_drained", exp_wr.size(), 0);
        chk("rd_drained", exp_rd.size(), 0);
        exp_done.delete(); exp_wr.delete(); exp_rd.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r0, h0, k;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {busy, done, err, s_ready, m_valid, avm_chipselect, avm_write, avm_byteenable}, 0);
        chk("rst_data", {m_data, avm_writedata, avm_address}, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", {cmd_ready, busy}, 2'b10);
        @(posedge clk); #1;

        // aligned 8-byte write at 0x10
        exp_wr.push_back('{a: 14'd4, be: 4'hF, d: 32'h04030201});
        exp_wr.push_back('{a: 14'd5, be: 4'hF, d: 32'h08070605});
        exp_done.push_back(1'b0);
        issue_cmd(1'b1, 16'h0010, 16'd8);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_done();
        chk("mem5", mem[5], 32'h08070605);

        // unaligned 3-byte write at 0x2
        exp_wr.push_back('{a: 14'd0, be: 4'hC, d: 32'hBBAA0000});
        exp_wr.push_back('{a: 14'd1, be: 4'h1, d: 32'h000000CC});
        exp_done.push_back(1'b0);
        issue_cmd(1'b1, 16'h0002, 16'd3);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_done();

        // unaligned 5-byte read at 0x3
        mem[0] = 32'h44332211; mem[1] = 32'h88776655;
        exp_rd.push_back(8'h44); exp_rd.push_back(8'h55); exp_rd.push_back(8'h66);
        exp_rd.push_back(8'h77); exp_rd.push_back(8'h88);
        exp_done.push_back(1'b0);
        r0 = n_reads;
        issue_cmd(1'b0, 16'h0003, 16'd5);
        wait_done();
        chk("rd5_reads", n_reads - r0, 2);

        // read with 4 cycles of backpressure mid-word
        mem[2] = 32'hA3A2A1A0;
        exp_rd.push_back(8'hA0); exp_rd.push_back(8'hA1);
        exp_rd.push_back(8'hA2); exp_rd.push_back(8'hA3);
        exp_done.push_back(1'b0);
        r0 = n_reads; h0 = n_hs;
        issue_cmd(1'b0, 16'h0008, 16'd4);
        k = 0;
        while (n_hs < h0 + 2 && k < 100) begin @(posedge clk); #1; k++; end
        m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_done();
        chk("bp_reads", n_reads - r0, 1);

        // last legal word of the RAM
        mem[DEPTH-1] = 32'hDDCCBBAA;
        exp_rd.push_back(8'hAA); exp_rd.push_back(8'hBB);
        exp_rd.push_back(8'hCC); exp_rd.push_back(8'hDD);
        exp_done.push_back(1'b0);
        r0 = n_reads;
        issue_cmd(1'b0, 16'h9FFC, 16'd4);
        wait_done();
        chk("top_reads", n_reads - r0, 1);

        // rejected: runs past the end of the RAM
        exp_done.push_back(1'b1);
        r0 = n_reads;
        issue_cmd(1'b0, 16'h9FFE, 16'd4);
        @(negedge clk);
        chk("rej_end_timing", {done, err}, 2'b11);
        wait_done();
        chk("rej_end_reads", n_reads - r0, 0);

        // rejected: zero length
        exp_done.push_back(1'b1);
        issue_cmd(1'b1, 16'h0100, 16'd0);
        @(negedge clk);
        chk("rej_len0_timing", {done, err}, 2'b11);
        wait_done();

        // reset in the middle of a fill: nothing is written
        mem[8] = 32'h0;
        issue_cmd(1'b1, 16'h0020, 16'd4);
        send_byte(8'h11); send_byte(8'h22);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctl", {busy, done, err, s_ready, m_valid, avm_chipselect, avm_write, avm_byteenable}, 0);
        chk("mid_rst_data", {m_data, avm_writedata, avm_address}, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {cmd_ready, busy}, 2'b10);
        chk("mid_rst_mem", mem[8], 32'h0);
        @(posedge clk); #1;
        exp_wr.push_back('{a: 14'd8, be: 4'hF, d: 32'hEFBEADDE});
        exp_done.push_back(1'b0);
        issue_cmd(1'b1, 16'h0020, 16'd4);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_done();
        chk("post_rst_mem", mem[8], 32'hEFBEADDE);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
